// File: rtl/mips_bus_pkg.sv
// Shared types and lane helpers for the MIPS load/store bus unit.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

  function automatic int off_w(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int size_bytes(input size_e s);
    case (s)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_lane_align.sv
// Combinational lane logic: byteenable mask, store shift and load merge/extend.
module mips_bus_lane_align
  import mips_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [off_w(DATA_W)-1:0] off,
  input  size_e                    size,
  input  logic                     sgn,
  input  logic                     hi,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W-1:0]        rd_lo,
  input  logic [DATA_W-1:0]        rd_hi,
  output logic [DATA_W/8-1:0]      be,
  output logic [DATA_W-1:0]        wd,
  output logic [DATA_W-1:0]        rdata
);

  localparam int LANES = lanes(DATA_W);

  int                  off_i;
  int                  nbytes;
  logic [2*LANES-1:0]  be_full;
  logic [2*DATA_W-1:0] wd_full;
  logic [DATA_W-1:0]   rd_m;
  logic                sign;

  // The access is laid out across two consecutive bus words; hi picks the upper one.
  always_comb begin
    off_i   = int'(off);
    nbytes  = size_bytes(size);
    be_full = '0;
    for (int i = 0; i < 2 * LANES; i++)
      if (i >= off_i && i < off_i + nbytes) be_full[i] = 1'b1;
    wd_full = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
    rd_m    = DATA_W'({rd_hi, rd_lo} >> {off, 3'b000});
    sign    = 1'b0;
    for (int b = 0; b < LANES; b++)
      if (b == nbytes - 1) sign = sgn & rd_m[8*b+7];
    rdata = '0;
    for (int b = 0; b < LANES; b++)
      rdata[8*b +: 8] = (b < nbytes) ? rd_m[8*b +: 8] : {8{sign}};
  end

  assign be = hi ? be_full[2*LANES-1:LANES] : be_full[LANES-1:0];
  assign wd = hi ? wd_full[2*DATA_W-1:DATA_W] : wd_full[DATA_W-1:0];

endmodule

// File: rtl/mips_bus_lsu.sv
// Load/store bus unit between the multicycle MIPS core and an Avalon-style bus.
// Define MIPS_BUS_UNALIGNED_EN to allow misaligned accesses (split into two beats if needed).
module mips_bus_lsu
  import mips_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int LANES = lanes(DATA_W);
  localparam int OFF_W = off_w(DATA_W);

  state_e            state;
  logic              live;
  logic [OFF_W-1:0]  lat_off;
  size_e             lat_size;
  logic              lat_signed;
  logic [OFF_W-1:0]  req_off;
  int                req_bytes;
  logic              req_legal;
  logic              idle;
  logic              fire;
  logic              done;
  logic [OFF_W-1:0]  al_off;
  size_e             al_size;
  logic              al_hi;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rd_lo;
  logic [DATA_W-1:0] al_wd;
  logic [DATA_W-1:0] al_rdata;
  logic [LANES-1:0]  al_be;
`ifdef MIPS_BUS_UNALIGNED_EN
  logic              split;
  logic              req_split;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rd1;
`endif

  // live keeps req_ready low while reset is held, without reset feeding the datapath
  assign idle      = (state == ST_IDLE);
  assign req_ready = idle & live;
  assign fire      = req_valid & req_ready;
  assign req_off   = req_addr[OFF_W-1:0];

  always_comb begin
    req_bytes = size_bytes(size_e'(req_size));
    req_legal = !((req_size == 2'b11) && (DATA_W == 32));
`ifdef MIPS_BUS_UNALIGNED_EN
    req_split = (int'(req_off) + req_bytes) > LANES;
`else
    if ((int'(req_off) & (req_bytes - 1)) != 0) req_legal = 1'b0;
`endif
  end

`ifdef MIPS_BUS_UNALIGNED_EN
  assign done     = ~waitrequest & ((state == ST_BEAT2) | ((state == ST_BEAT1) & ~split));
  assign al_hi    = (state == ST_BEAT1);
  assign al_wdata = idle ? req_wdata : lat_wdata;
  assign al_rd_lo = (state == ST_BEAT2) ? rd1 : readdata;
`else
  assign done     = ~waitrequest & (state == ST_BEAT1);
  assign al_hi    = 1'b0;
  assign al_wdata = req_wdata;
  assign al_rd_lo = readdata;
`endif
  assign al_off  = idle ? req_off : lat_off;
  assign al_size = idle ? size_e'(req_size) : lat_size;

  mips_bus_lane_align #(.DATA_W(DATA_W)) u_align (
    .off   (al_off),
    .size  (al_size),
    .sgn   (lat_signed),
    .hi    (al_hi),
    .wdata (al_wdata),
    .rd_lo (al_rd_lo),
    .rd_hi (readdata),
    .be    (al_be),
    .wd    (al_wd),
    .rdata (al_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      live       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      live       <= 1'b1;
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: if (fire) begin
          resp_rdata <= '0;
          if (req_legal) begin
            state      <= ST_BEAT1;
            address    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            read       <= ~req_write;
            write      <= req_write;
            byteenable <= al_be;
            writedata  <= al_wd;
            resp_err   <= 1'b0;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end
        end
        ST_BEAT1, ST_BEAT2: begin
          if (done) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            resp_rdata <= write ? '0 : al_rdata;
          end
`ifdef MIPS_BUS_UNALIGNED_EN
          else if (!waitrequest) begin
            state      <= ST_BEAT2;
            address    <= address + ADDR_W'(LANES);
            byteenable <= al_be;
            writedata  <= al_wd;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
      endcase
    end
  end

  // Request fields and first-beat load data are plain data registers
  always_ff @(posedge clk) begin
    if (fire) begin
      lat_off    <= req_off;
      lat_size   <= size_e'(req_size);
      lat_signed <= req_signed;
`ifdef MIPS_BUS_UNALIGNED_EN
      lat_wdata  <= req_wdata;
      split      <= req_split;
`endif
    end
`ifdef MIPS_BUS_UNALIGNED_EN
    if (state == ST_BEAT1 && !waitrequest) rd1 <= readdata;
`endif
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Randomized bench for mips_bus_lsu against a byte-level memory reference model.
module tb_mips_bus_lsu;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LANES = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write, req_signed;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] address;
  logic          read, write, waitrequest;
  logic [DW-1:0] writedata, readdata;
  logic [LANES-1:0] byteenable;

  always #5 clk = ~clk;

  mips_bus_lsu #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  bus_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] seen_addr [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[3:0], a[7:4]} ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      bus_mem[a + 32'(i)] = 8'(v >> (8 * i));
      ref_mem[a + 32'(i)] = 8'(v >> (8 * i));
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int w1, input int w2,
                        output logic [31:0] rd_o, output logic err_o);
    int n, nbeats, exp_lat, beat, cyc, wbytes, lane;
    int waits [2];
    logic legal, got_resp;
    logic [31:0] ba [2];
    logic [31:0] exp_rd, exp_wd, wmask, a, rdw, snap_addr;
    logic [LANES-1:0] exp_be;
    logic [37:0] snap_ctl;
    n = 1 << sz;
    legal = !(sz == 2'b11 && DW == 32);
`ifndef MIPS_BUS_UNALIGNED_EN
    if ((addr % n) != 0) legal = 1'b0;
`endif
    ba[0]    = addr & ~32'(LANES - 1);
    ba[1]    = ba[0] + 32'(LANES);
    nbeats   = !legal ? 0 : ((int'(addr % LANES) + n > LANES) ? 2 : 1);
    waits[0] = w1;
    waits[1] = w2;
    exp_lat  = !legal ? 1 : (1 + (w1 + 1) + ((nbeats == 2) ? w2 + 1 : 0));
    exp_rd   = '0;
    if (legal && !wr) begin
      for (int j = 0; j < n; j++) exp_rd |= 32'(ref_rd(addr + 32'(j))) << (8 * j);
      if (sg && ((exp_rd >> (8 * n - 1)) & 32'd1) != 0)
        for (int j = n; j < LANES; j++) exp_rd |= 32'hFF << (8 * j);
    end
    if (legal && wr)
      for (int j = 0; j < n; j++) ref_mem[addr + 32'(j)] = 8'(wd >> (8 * j));

    @(negedge clk);
    check("rdy_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size = sz; req_signed = sg; req_wdata = wd;
    @(posedge clk);
    beat = 0; cyc = 0; wbytes = 0; got_resp = 1'b0; rd_o = '0; err_o = 1'b0;
    snap_addr = '0; snap_ctl = '0;
    for (int k = 1; k <= 40 && !got_resp; k++) begin
      @(negedge clk);
      req_write = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
      req_signed = 1'($urandom); req_wdata = $urandom;
      readdata = $urandom; waitrequest = 1'($urandom);
      if (resp_valid) begin
        got_resp = 1'b1; req_valid = 1'b0;
        check("latency", k, exp_lat);
        check("resp_err", resp_err, !legal);
        check("resp_rdata", resp_rdata, exp_rd);
        rd_o = resp_rdata; err_o = resp_err;
      end else begin
        check("busy_rdy", req_ready, 0);
        check("rd_wr_excl", read & write, 0);
        if (read || write) begin
          if (beat >= nbeats) begin
            check("extra_beat", beat + 1, nbeats);
            waitrequest = 1'b0;
            beat++;
          end else begin
            if (cyc == 0) begin
              exp_be = '0; exp_wd = '0; wmask = '0;
              for (int j = 0; j < n; j++) begin
                a = addr + 32'(j);
                if ((a & ~32'(LANES - 1)) == ba[beat]) begin
                  lane = int'(a % LANES);
                  exp_be |= LANES'(1 << lane);
                  exp_wd |= ((wd >> (8 * j)) & 32'hFF) << (8 * lane);
                  wmask  |= 32'hFF << (8 * lane);
                end
              end
              check("beat_addr", address, ba[beat]);
              check("beat_cmd", {read, write}, {!wr, wr});
              check("beat_be", byteenable, exp_be);
              if (wr) check("beat_wdata", writedata & wmask, exp_wd);
              seen_addr[beat] = address;
              snap_addr = address;
              snap_ctl  = {byteenable, writedata, read, write};
            end else begin
              check("hold_addr", address, snap_addr);
              check("hold_ctl", {byteenable, writedata, read, write}, snap_ctl);
            end
            if (cyc < waits[beat]) begin
              waitrequest = 1'b1;
              cyc++;
            end else begin
              waitrequest = 1'b0;
              if (read) begin
                rdw = '0;
                for (int i = 0; i < LANES; i++) rdw |= 32'(bus_rd(address + 32'(i))) << (8 * i);
                readdata = rdw;
              end
              if (write)
                for (int i = 0; i < LANES; i++)
                  if (((byteenable >> i) & 1'b1) != 0) begin
                    bus_mem[address + 32'(i)] = 8'(writedata >> (8 * i));
                    wbytes++;
                  end
              cyc = 0;
              beat++;
            end
          end
        end
      end
    end
    req_valid = 1'b0;
    check("resp_seen", got_resp, 1);
    check("beats", beat, nbeats);
    check("wbytes", wbytes, (legal && wr) ? n : 0);
    if (legal && wr)
      for (int j = 0; j < n; j++) check("store_byte", bus_rd(addr + 32'(j)), ref_rd(addr + 32'(j)));
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_rdy", req_ready, 0);
    check("rst_cmd", {read, write}, 0);
    check("rst_addr", address, 0);
    check("rst_be_wd", {byteenable, writedata}, 0);
    check("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("rdy_after_rst", req_ready, 1);

    preload(32'h1000, 32'h80FFFFFF);
    do_req(1'b0, 32'h1003, 2'b00, 1'b1, 32'h0, 0, 0, rd, er);
    check("dir_sbyte", rd, 32'hFFFFFF80);
    do_req(1'b1, 32'h2002, 2'b01, 1'b0, 32'hBEEF, 3, 0, rd, er);
    check("dir_half_st", {bus_rd(32'h2003), bus_rd(32'h2002)}, 16'hBEEF);
    preload(32'h3000, 32'h44332211);
    preload(32'h3004, 32'h88776655);
    do_req(1'b0, 32'h3001, 2'b10, 1'b0, 32'h0, 0, 0, rd, er);
`ifdef MIPS_BUS_UNALIGNED_EN
    check("dir_split_rd", rd, 32'h55443322);
    check("dir_split_a2", seen_addr[1], 32'h3004);
`else
    check("dir_mis_err", er, 1);
`endif
    do_req(1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0, 1, 1, rd, er);
`ifdef MIPS_BUS_UNALIGNED_EN
    check("dir_wrap_a2", seen_addr[1], 32'h0);
`else
    check("dir_wrap_err", er, 1);
`endif
    do_req(1'b0, 32'h40, 2'b11, 1'b0, 32'h0, 0, 0, rd, er);
    check("dir_dword_err", er, 1);

    // Reset in the middle of a stalled read
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; req_size = 2'b10;
    req_signed = 1'b0; waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mr_read_on", read, 1);
    #2 reset = 1'b1;
    #1 check("mr_read_drop", read, 0);
    check("mr_no_resp", resp_valid, 0);
    repeat (2) begin
      @(negedge clk);
      check("mr_rdy_low", req_ready, 0);
    end
    reset = 1'b0;
    waitrequest = 1'b0;
    @(posedge clk);
    #1 check("mr_rdy_after", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("mr_quiet", {resp_valid, read, write}, 0);
    end

    for (int t = 0; t < 300; t++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 9) == 0) ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else                           ra = 32'h100 + 32'($urandom_range(0, 63));
      do_req(1'($urandom), ra, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_lsu.md
# mips_bus_lsu

Parametrised load/store bus unit between the multicycle MIPS core and the Avalon-style memory bus (address/read/write/waitrequest/byteenable). It accepts one core memory request at a time and performs byte-lane alignment, byteenable generation, sub-word sign/zero extension and waitrequest stalling. Optionally, it splits boundary-crossing unaligned accesses into two bus beats. It replaces the ad-hoc byteenable/stall logic currently spread across the decoder and datapath.

## Interface
- DATA_W, 32: bus and core data width; 32 or 64.
- ADDR_W, 32: byte address width.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- req_signed  in  1  sign-extend a load result (ignored for stores).
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle pulse; response fields valid.
- resp_rdata  out  DATA_W  load data, right-justified and extended; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned or illegal size); no bus traffic occurred.
- address  out  ADDR_W  bus word address; low log2(DATA_W/8) bits always 0.
- read  out  1  bus read command.
- write  out  1  bus write command.
- waitrequest  in  1  bus stall; command must be held while high.
- writedata  out  DATA_W  lane-positioned store data.
- byteenable  out  DATA_W/8  active lanes, little-endian (lane i = bits 8i+7:8i).
- readdata  in  DATA_W  bus read data; valid in the cycle read=1 and waitrequest=0.

## Operation
- States: IDLE, BEAT1, BEAT2, RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches the request.
  - Legal request → BEAT1.
  - Illegal request → RESP with err=1.
- Legality without split:
  - offset = addr mod (DATA_W/8) must be a multiple of the access size.
  - size=11 with DATA_W=32 is always illegal.
- BEAT1: drive address = aligned addr, read or write, byteenable = ((1<<bytes)-1) << offset (truncated to lane count), writedata = req_wdata << 8*offset. Hold all bus outputs stable while waitrequest=1.
  - On an edge with waitrequest=0 → BEAT2 if split is needed, else RESP.
  - Loads capture readdata on that edge.
- BEAT2 (split builds only): address = aligned addr + DATA_W/8, wrapping modulo 2^ADDR_W. Drive the remaining upper bytes in lanes 0 upward with the matching byteenable. On waitrequest=0 → RESP.
- Load data assembly: beat1 data >> 8*offset, OR'd with beat2 data << 8*(DATA_W/8−offset), masked to the access size. Sign/zero extension uses the top byte of the access size.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE. There is no response backpressure.
- read and write are never both 1. Both are 0 in IDLE and RESP.

## Timing
- Reset (async) values:
  - state=IDLE; read=0, write=0, address=0, byteenable=0, writedata=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=0 while reset is high, then 1 in the first cycle after release.
- Bus outputs are registered. A request accepted at edge T drives the bus in cycle T+1.
- Zero-wait single beat: resp_valid in cycle T+2. Each waitrequest cycle adds 1. A split adds 1 plus that beat's waits.
- Error response: resp_valid in cycle T+1; no bus command.
- Reset mid-transaction: bus commands drop immediately and the request is discarded with no response.
- req_valid during BEAT1/BEAT2/RESP is ignored (req_ready=0). The earliest next accept is the RESP cycle's following IDLE cycle.

## Configuration
- MIPS_BUS_UNALIGNED_EN defined:
  - A misaligned access that fits in one bus word completes in one beat.
  - An access crossing a bus-word boundary is split into two beats.
  - Only size=11 on a 32-bit bus raises resp_err.
- MIPS_BUS_UNALIGNED_EN undefined:
  - Any non-natural alignment gives resp_err=1.
  - BEAT2 and its logic are not compiled.

## Structure
- Package mips_bus_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - the state enum;
  - the lane-count/offset-width function of DATA_W.
- One combinational sub-module, mips_bus_lane_align, holds the byteenable mask, the write shift, and the read merge/extend. It is shared by both beats.

## Test plan
- DATA_W=32, signed byte load at 0x1003, readdata=0x80FFFFFF, no wait:
  - address=0x1000, byteenable=1000;
  - resp_rdata=0xFFFFFF80, resp_valid in cycle T+2.
- Half store 0xBEEF at 0x2002, waitrequest high 3 cycles:
  - address, writedata=0xBEEF0000 and byteenable=1100 held stable for 4 cycles;
  - resp_valid in cycle T+5.
- Word load at 0x3001 without the macro:
  - resp_err=1, resp_valid in cycle T+1, read never asserted.
- Same load with MIPS_BUS_UNALIGNED_EN, beat1 readdata=0x44332211, beat2 readdata=0x88776655:
  - addresses 0x3000 then 0x3004;
  - resp_rdata=0x55443322.
- Split at address 0xFFFFFFFE (word, macro on): second beat address=0x00000000.
- Reset asserted during BEAT1 with waitrequest=1:
  - read drops to 0 asynchronously, no resp_valid;
  - req_ready=1 in the first cycle after release.
